// File: rtl/branch_resolve_predict_if.sv
// Bundle of IF-lookup, EX-resolve and status signals for branch_resolve_predict.
// master = pipeline side driving requests, slave = the predictor/resolver.
interface branch_resolve_predict_if #(
    parameter int XLEN = 32
);
    logic            clear_req;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            ex_stall;
    logic [3:0]      ex_branch;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            ex_taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
    logic            state_dbg;  // 0 = INIT sweep, 1 = READY

    // No valid/ready handshake here: ex_valid qualifies the EX slot each
    // cycle and ex_stall freezes side effects; outputs are combinational
    // except the table, stats and state, which change at the clock edge.
    modport master (
        output clear_req, if_pc, ex_valid, ex_stall, ex_branch,
               ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_taken,
        input  if_pred_taken, ex_taken, mispredict, redirect_pc, busy,
               stat_branches, stat_mispredicts, state_dbg
    );

    modport slave (
        input  clear_req, if_pc, ex_valid, ex_stall, ex_branch,
               ex_rs1, ex_rs2, ex_pc, ex_target, ex_pred_taken,
        output if_pred_taken, ex_taken, mispredict, redirect_pc, busy,
               stat_branches, stat_mispredicts, state_dbg
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver with a 2-bit saturating-counter BHT, init sweep
// sequencer and saturating branch/mispredict statistics.
module branch_resolve_predict #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input logic                  CLK,
    input logic                  RESETN,
    branch_resolve_predict_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_ENTRIES - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [1:0]       bht [BHT_ENTRIES];
    logic [31:0]      stat_br_q, stat_mp_q;

    logic             br, taken, busy, upd, misp;
    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [1:0]       ctr_old, ctr_new;
    logic             unused_if_pc_bits;

    assign br     = bus.ex_valid & bus.ex_branch[3];
    assign busy   = (state_q == ST_INIT);
    assign upd    = br & ~bus.ex_stall & ~busy;
    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign unused_if_pc_bits = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:IDX_W+2]};

    always_comb begin
        taken = 1'b0;
        case (bus.ex_branch[2:0])
            3'b000:  taken = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  taken = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  taken = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: taken = 1'b0;
        endcase
        if (!br) taken = 1'b0;
    end

    // Fetch predicts not-taken while sweeping, so no mispredict can be owed then.
    assign misp              = br & ~busy & (taken != bus.ex_pred_taken);
    assign bus.ex_taken      = taken;
    assign bus.mispredict    = misp;
    assign bus.redirect_pc   = taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
    assign bus.if_pred_taken = ~busy & bht[if_idx][1];
    assign bus.busy          = busy;
    assign bus.state_dbg     = state_q;
    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;

    always_comb begin
        ctr_old = bht[ex_idx];
        ctr_new = ctr_old;
        if (taken) begin
            if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
        end else begin
            if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                if (bus.clear_req) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_IDX) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Table has no reset; the sweep initialises it, and the read is not bypassed.
    always_ff @(posedge CLK) begin
        if (busy) begin
            bht[ptr_q] <= CTR_INIT;
        end else if (upd) begin
            bht[ex_idx] <= ctr_new;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (upd) begin
            if (stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
            if (misp && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: compares, BHT training and
// saturation, init sweep timing, stall gating and statistics saturation.
module tb_branch_resolve_predict;
    localparam logic [2:0] F_BEQ = 3'b000, F_BNE = 3'b001, F_BLT = 3'b100,
                           F_BGE = 3'b101, F_BLTU = 3'b110, F_BGEU = 3'b111;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cnt;

    branch_resolve_predict_if #(.XLEN(32)) bus ();

    branch_resolve_predict #(
        .XLEN(32), .BHT_ENTRIES(64), .CTR_INIT(2'b01)
    ) dut (
        .CLK(clk),
        .RESETN(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        bus.ex_valid      = 1'b0;
        bus.ex_stall      = 1'b0;
        bus.ex_branch     = 4'b0000;
        bus.ex_rs1        = '0;
        bus.ex_rs2        = '0;
        bus.ex_pc         = '0;
        bus.ex_target     = '0;
        bus.ex_pred_taken = 1'b0;
        #1;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pred, input logic stall);
        bus.ex_valid      = 1'b1;
        bus.ex_stall      = stall;
        bus.ex_branch     = {1'b1, f3};
        bus.ex_rs1        = a;
        bus.ex_rs2        = b;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pred;
        #1;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        bus.if_pc = pc;
        #1;
        check_val(tag, {31'd0, bus.if_pred_taken}, {31'd0, exp});
    endtask

    // Compare vectors: funct3, rs1, rs2, expected ex_taken
    logic [2:0]  v_f3 [12] = '{F_BLT, F_BLTU, F_BGE, F_BGE, F_BGEU, F_BLTU,
                               F_BEQ, F_BNE, F_BNE, 3'b010, 3'b011, F_BLT};
    logic [31:0] v_a  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'd1, 32'd1,
                               32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'h8000_0000};
    logic [31:0] v_b  [12] = '{32'd1, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd7, 32'd7, 32'd8, 32'd7, 32'd1, 32'h7FFF_FFFF};
    logic        v_t  [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        nt_pred [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.clear_req = 1'b0;
        bus.if_pc = '0;
        idle_ex();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, bus.busy}, 32'd1);
        check_val("rst_state", {31'd0, bus.state_dbg}, 32'd0);
        check_val("rst_stat_br", bus.stat_branches, 32'd0);
        check_val("rst_stat_mp", bus.stat_mispredicts, 32'd0);

        // Power-up sweep: busy for exactly 64 cycles, predictions 0 throughout.
        rst_n = 1'b1;
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            bus.if_pc = $urandom;
            #1;
            check_val("sweep_pred", {31'd0, bus.if_pred_taken}, 32'd0);
            tick();
            cnt++;
        end
        check_val("sweep_len", cnt, 32'd64);
        check_val("ready_state", {31'd0, bus.state_dbg}, 32'd1);
        pred_at("init_pred_0", 32'h0000_0000, 1'b0);
        pred_at("init_pred_100", 32'h0000_0100, 1'b0);
        pred_at("init_pred_fc", 32'h0000_00FC, 1'b0);
        pred_at("init_pred_top", 32'hFFFF_FFFC, 1'b0);

        // Resolver compares, stalled so nothing is recorded.
        for (int i = 0; i < 12; i++) begin
            drive_br(v_f3[i], v_a[i], v_b[i], 32'h0000_0200, 32'h0000_0300, 1'b0, 1'b1);
            check_val($sformatf("cmp_%0d", i), {31'd0, bus.ex_taken}, {31'd0, v_t[i]});
        end
        drive_br(F_BEQ, 32'd4, 32'd4, 32'h200, 32'h300, 1'b0, 1'b1);
        bus.ex_branch = 4'b0000;
        #1;
        check_val("not_branch", {31'd0, bus.ex_taken}, 32'd0);
        bus.ex_branch = 4'b1000;
        bus.ex_valid = 1'b0;
        #1;
        check_val("not_valid", {31'd0, bus.ex_taken}, 32'd0);
        check_val("not_valid_mp", {31'd0, bus.mispredict}, 32'd0);

        // Stalled taken branch: outputs live, table and stats untouched.
        bus.if_pc = 32'h100;
        drive_br(F_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h180, 1'b0, 1'b1);
        check_val("stall_taken", {31'd0, bus.ex_taken}, 32'd1);
        check_val("stall_mp", {31'd0, bus.mispredict}, 32'd1);
        check_val("stall_redir", bus.redirect_pc, 32'h180);
        tick();
        idle_ex();
        check_val("stall_stat_br", bus.stat_branches, 32'd0);
        check_val("stall_stat_mp", bus.stat_mispredicts, 32'd0);
        pred_at("stall_pred", 32'h100, 1'b0);

        // Train index 0 (pc 0x100) taken twice with predicted not-taken.
        bus.if_pc = 32'h100;
        drive_br(F_BEQ, 32'd3, 32'd3, 32'h100, 32'h200, 1'b0, 1'b0);
        check_val("t1_taken", {31'd0, bus.ex_taken}, 32'd1);
        check_val("t1_mp", {31'd0, bus.mispredict}, 32'd1);
        check_val("t1_redir", bus.redirect_pc, 32'h200);
        check_val("t1_pred_old", {31'd0, bus.if_pred_taken}, 32'd0);
        tick();
        check_val("t2_mp", {31'd0, bus.mispredict}, 32'd1);
        check_val("t2_pred_old", {31'd0, bus.if_pred_taken}, 32'd1);
        tick();
        idle_ex();
        pred_at("t2_pred", 32'h100, 1'b1);
        check_val("t2_stat_br", bus.stat_branches, 32'd2);
        check_val("t2_stat_mp", bus.stat_mispredicts, 32'd2);
        drive_br(F_BEQ, 32'd3, 32'd3, 32'h100, 32'h200, 1'b1, 1'b0);
        check_val("t3_mp", {31'd0, bus.mispredict}, 32'd0);
        tick();
        // Counter at 3; four not-taken resolutions walk it down and hold at 0.
        for (int i = 0; i < 4; i++) begin
            drive_br(F_BEQ, 32'd3, 32'd4, 32'h100, 32'h200, nt_pred[i == 0 ? 0 : 1] | (i < 3), 1'b0);
            check_val($sformatf("nt%0d_taken", i), {31'd0, bus.ex_taken}, 32'd0);
            check_val($sformatf("nt%0d_redir", i), bus.redirect_pc, 32'h104);
            check_val($sformatf("nt%0d_mp", i), {31'd0, bus.mispredict}, (i < 3) ? 32'd1 : 32'd0);
            tick();
            idle_ex();
            pred_at($sformatf("nt%0d_pred", i), 32'h100, nt_pred[i]);
        end
        check_val("nt_stat_br", bus.stat_branches, 32'd7);
        check_val("nt_stat_mp", bus.stat_mispredicts, 32'd5);

        // Not-taken at the top of the address space: fall-through wraps to 0.
        drive_br(F_BNE, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0);
        check_val("wrap_taken", {31'd0, bus.ex_taken}, 32'd0);
        check_val("wrap_mp", {31'd0, bus.mispredict}, 32'd1);
        check_val("wrap_redir", bus.redirect_pc, 32'h0);
        tick();
        idle_ex();
        check_val("wrap_stat_br", bus.stat_branches, 32'd8);
        check_val("wrap_stat_mp", bus.stat_mispredicts, 32'd6);

        // Same-cycle lookup and update on index 1.
        bus.if_pc = 32'h104;
        drive_br(F_BGEU, 32'd9, 32'd2, 32'h104, 32'h500, 1'b0, 1'b0);
        check_val("same_pred_old", {31'd0, bus.if_pred_taken}, 32'd0);
        tick();
        idle_ex();
        pred_at("same_pred_new", 32'h104, 1'b1);

        // Train index 0 back up to 3, then re-initialise with clear_req.
        for (int i = 0; i < 3; i++) begin
            drive_br(F_BNE, 32'd1, 32'd2, 32'h100, 32'h200, 1'b1, 1'b0);
            tick();
        end
        idle_ex();
        pred_at("retrain_pred", 32'h100, 1'b1);
        check_val("retrain_stat_br", bus.stat_branches, 32'd12);
        check_val("retrain_stat_mp", bus.stat_mispredicts, 32'd7);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_val("clr_busy", {31'd0, bus.busy}, 32'd1);
        drive_br(F_BEQ, 32'd1, 32'd1, 32'h100, 32'h240, 1'b0, 1'b0);
        check_val("clr_taken", {31'd0, bus.ex_taken}, 32'd1);
        check_val("clr_redir", bus.redirect_pc, 32'h240);
        check_val("clr_mp_forced", {31'd0, bus.mispredict}, 32'd0);
        tick();
        idle_ex();
        repeat (9) tick();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check_val("restart_len", cnt, 32'd64);
        pred_at("clr_pred_100", 32'h100, 1'b0);
        pred_at("clr_pred_104", 32'h104, 1'b0);
        check_val("clr_stat_br", bus.stat_branches, 32'd12);
        check_val("clr_stat_mp", bus.stat_mispredicts, 32'd7);

        // Statistics saturation.
        force dut.stat_br_q = 32'hFFFF_FFFE;
        force dut.stat_mp_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_br_q;
        release dut.stat_mp_q;
        drive_br(F_BEQ, 32'd1, 32'd1, 32'h300, 32'h400, 1'b0, 1'b0);
        tick();
        check_val("sat1_stat_br", bus.stat_branches, 32'hFFFF_FFFF);
        check_val("sat1_stat_mp", bus.stat_mispredicts, 32'hFFFF_FFFF);
        tick();
        check_val("sat2_stat_br", bus.stat_branches, 32'hFFFF_FFFF);
        check_val("sat2_stat_mp", bus.stat_mispredicts, 32'hFFFF_FFFF);

        // Reset mid-operation.
        rst_n = 1'b0;
        #1;
        check_val("rst2_busy", {31'd0, bus.busy}, 32'd1);
        check_val("rst2_state", {31'd0, bus.state_dbg}, 32'd0);
        check_val("rst2_stat_br", bus.stat_branches, 32'd0);
        check_val("rst2_mp", {31'd0, bus.mispredict}, 32'd0);
        idle_ex();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
- Successor to the EX-stage branch comparator.
- Resolves conditional branches in EX and keeps a parametrised table of 2-bit saturating counters (BHT).
- Gives IF a taken/not-taken prediction and reports mispredictions and the redirect PC to the hazard/PC-select logic.
- Provides signed-correct compares, a table-init sequencer and saturating performance counters.

Parameters:
- XLEN, 32, operand/PC width.
- BHT_ENTRIES, 64, counter-table depth; power of 2, at least 4.
- CTR_INIT, 2'b01, counter value written on init (weakly not-taken).

Ports:
- CLK  in  1  clock.
- RESETN  in  1  asynchronous active-low reset.
- clear_req  in  1  single-cycle pulse: re-initialise the BHT.
- if_pc  in  XLEN  fetch PC used for prediction lookup.
- if_pred_taken  out  1  prediction for if_pc.
- ex_valid  in  1  EX slot holds a valid instruction.
- ex_stall  in  1  EX frozen; suppresses table and stat updates.
- ex_branch  in  4  bit3 = conditional branch; bits2:0 = funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- ex_rs1, ex_rs2  in  XLEN  forwarded operands.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_target  in  XLEN  computed branch target.
- ex_pred_taken  in  1  prediction carried down the pipe from IF.
- ex_taken  out  1  resolved outcome.
- mispredict  out  1  outcome differs from prediction.
- redirect_pc  out  XLEN  correct next PC when mispredict = 1.
- busy  out  1  table init in progress.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

Behaviour:
- IDX_W = log2(BHT_ENTRIES). Index = pc[IDX_W+1:2] for both if_pc and ex_pc.
- Resolve (combinational), with br = ex_valid & ex_branch[3]:
  - BEQ: rs1 == rs2. BNE: rs1 != rs2.
  - BLT / BGE: signed compare, < and >=.
  - BLTU / BGEU: unsigned compare, < and >=.
  - funct3 010 or 011: ex_taken = 0.
  - ex_taken = 0 whenever br = 0.
- mispredict = br & ~busy & (ex_taken != ex_pred_taken).
- redirect_pc = ex_taken ? ex_target : ex_pc + 4, truncated to XLEN (wraps at all-ones).
- Prediction: if_pred_taken = ~busy & ctr[idx(if_pc)][1]. The read is combinational from the array.
- The table is a registered write. A same-cycle write to the same index is NOT bypassed; lookup returns the pre-update value.
- Update, at the edge, when br & ~ex_stall & ~busy:
  - taken: counter increments, saturating at 3.
  - not taken: counter decrements, saturating at 0.
  - Only the ex_pc entry changes.
- FSM states INIT and READY:
  - Reset: state = INIT, sweep ptr = 0.
  - INIT: writes CTR_INIT to entry ptr each cycle, ptr increments. After writing entry BHT_ENTRIES-1, moves to READY. Takes exactly BHT_ENTRIES cycles. busy = 1 throughout.
  - During INIT, EX updates are dropped and stats are frozen. ex_taken and redirect_pc still resolve; mispredict is forced to 0 (fetch predicts not-taken while busy, so the pipe has no wrong-path state from the BHT).
  - READY: clear_req = 1 moves to INIT with ptr = 0 next cycle. A simultaneous EX update in that cycle is still applied, then overwritten by the sweep.
  - clear_req during INIT restarts the sweep at ptr = 0.
- Stats, when br & ~ex_stall & ~busy:
  - stat_branches increments.
  - stat_mispredicts increments when mispredict = 1.
  - Both saturate at 32'hFFFFFFFF.
  - Cleared only by reset, not by clear_req.
- Reset values:
  - state INIT, ptr 0, busy 1.
  - stat_branches 0, stat_mispredicts 0.
  - Counter array is not reset directly; it is initialised by the sweep.
- Reset asserted mid-sweep or mid-update: immediate return to INIT with ptr 0. Any pending update is lost.

Test Plan:
- Reset, idle: busy = 1 for exactly 64 cycles, then 0. Every if_pc predicts 0 during the sweep and after it (CTR_INIT = 01).
- BLT rs1 = 32'hFFFFFFFF, rs2 = 1 -> ex_taken = 1. BLTU with the same operands -> ex_taken = 0. BGE with rs1 = rs2 -> ex_taken = 1.
- Branch at ex_pc = 0x100 taken twice, ex_pred_taken = 0: both cycles mispredict = 1, redirect_pc = ex_target. Then if_pc = 0x100 predicts 1. Third taken saturates the counter at 3. Three not-taken resolutions bring the counter to 0.
- Not-taken BNE with equal operands at ex_pc = 0xFFFFFFFC, ex_pred_taken = 1 -> mispredict = 1, redirect_pc = 0x00000000 (wrap).
- ex_stall = 1 with a valid branch -> counter and stats unchanged, but ex_taken/mispredict still driven. Same-cycle lookup and update on the same index -> old prediction returned, new value visible next cycle.
- clear_req after training index 0 to 3 -> busy 64 cycles, prediction for index 0 back to 0, stats retained. Force stat_branches to 32'hFFFFFFFF -> further branches leave it unchanged.
